// File: rtl/nfi_scheduler.sv
// nfi_scheduler: decides when the next-field-iteration engine computes a new
// generation. Handles speed levels, pause/resume, single-step, the go/done
// handshake with the engine and a count of completed generations.
`timescale 1ns/1ps
module nfi_scheduler #(
  parameter int BASE_PERIOD  = 4,
  parameter int N_SPEEDS     = 4,
  parameter int RESET_SPEED  = 0,
  parameter int START_PAUSED = 0,
  parameter int GEN_W        = 16
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 i_cmd_toggle_pause,
  input  logic                                                 i_cmd_step,
  input  logic                                                 i_cmd_speed_up,
  input  logic                                                 i_cmd_speed_down,
  input  logic                                                 i_NFI_allowed,
  input  logic                                                 i_done,
  output logic                                                 o_go,
  output logic                                                 o_busy,
  output logic                                                 o_paused,
  output logic [((N_SPEEDS > 1) ? $clog2(N_SPEEDS) : 1)-1:0]   o_speed,
  output logic [GEN_W-1:0]                                     o_gen_cnt
);

  localparam int SPEED_W    = (N_SPEEDS > 1) ? $clog2(N_SPEEDS) : 1;
  localparam int MAX_PERIOD = BASE_PERIOD << (N_SPEEDS - 1);
  localparam int CNT_W      = (MAX_PERIOD > 1) ? $clog2(MAX_PERIOD) : 1;
  localparam logic [31:0]        BASE      = 32'(BASE_PERIOD);
  localparam logic [31:0]        TOP_SPEED = 32'(N_SPEEDS - 1);
  localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(N_SPEEDS - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    ISSUE  = 2'd2,
    BUSY   = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next, period_m1;
  logic [31:0]        period_full;
  logic               paused, paused_next;
  logic [SPEED_W-1:0] speed, speed_next;
  logic [GEN_W-1:0]   gen_cnt, gen_next;
  logic               tog_prev, step_prev, up_prev, down_prev;
  logic               tog_ev, step_ev, up_ev, down_ev;

  // One event per rising edge of each command level.
  assign tog_ev  = i_cmd_toggle_pause & ~tog_prev;
  assign step_ev = i_cmd_step         & ~step_prev;
  assign up_ev   = i_cmd_speed_up     & ~up_prev;
  assign down_ev = i_cmd_speed_down   & ~down_prev;

  // Period of the current level, minus one; a full power-of-two period wraps
  // to all-ones at CNT_W, which is exactly the terminal count needed.
  assign period_full = BASE << (TOP_SPEED - 32'(speed));
  assign period_m1   = CNT_W'(period_full - 32'd1);

  assign o_paused  = paused;
  assign o_speed   = speed;
  assign o_gen_cnt = gen_cnt;

  // Pause flag flips on every toggle event regardless of state.
  always_comb begin
    paused_next = paused;
    if (tog_ev) begin
      paused_next = ~paused;
    end else begin
      paused_next = paused;
    end
  end

  // Speed level: saturating up/down, simultaneous events cancel.
  always_comb begin
    speed_next = speed;
    if (up_ev && !down_ev) begin
      if (speed != SPEED_MAX) speed_next = speed + SPEED_W'(1);
      else                    speed_next = speed;
    end else if (down_ev && !up_ev) begin
      if (speed != SPEED_W'(0)) speed_next = speed - SPEED_W'(1);
      else                      speed_next = speed;
    end else begin
      speed_next = speed;
    end
  end

  // Next-state, period counter and generation counter.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    gen_next   = gen_cnt;
    case (state)
      RUN: begin
        if (paused_next) begin
          state_next = PAUSED;
          cnt_next   = CNT_W'(0);
        end else if (i_NFI_allowed) begin
          if (cnt >= period_m1) begin
            state_next = ISSUE;
            cnt_next   = CNT_W'(0);
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end else begin
          cnt_next = cnt;
        end
      end
      PAUSED: begin
        cnt_next = CNT_W'(0);
        if (step_ev)           state_next = ISSUE;
        else if (!paused_next) state_next = RUN;
        else                   state_next = PAUSED;
      end
      ISSUE: begin
        cnt_next   = CNT_W'(0);
        state_next = BUSY;
      end
      BUSY: begin
        cnt_next = CNT_W'(0);
        if (i_done) begin
          gen_next   = gen_cnt + GEN_W'(1);
          state_next = paused_next ? PAUSED : RUN;
        end else begin
          state_next = BUSY;
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = CNT_W'(0);
      end
    endcase
  end

  // State, counters, edge-detect history and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= (START_PAUSED != 0) ? PAUSED : RUN;
      cnt       <= CNT_W'(0);
      paused    <= (START_PAUSED != 0);
      speed     <= SPEED_W'(RESET_SPEED);
      gen_cnt   <= GEN_W'(0);
      tog_prev  <= 1'b0;
      step_prev <= 1'b0;
      up_prev   <= 1'b0;
      down_prev <= 1'b0;
      o_go      <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      paused    <= paused_next;
      speed     <= speed_next;
      gen_cnt   <= gen_next;
      tog_prev  <= i_cmd_toggle_pause;
      step_prev <= i_cmd_step;
      up_prev   <= i_cmd_speed_up;
      down_prev <= i_cmd_speed_down;
      o_go      <= (state_next == ISSUE);
      o_busy    <= (state_next == BUSY);
    end
  end

endmodule

// File: tb/tb_nfi_scheduler.sv
// Directed bench for nfi_scheduler: per-cycle vector table for step/speed
// behaviour plus hand-written sequences for timing, stall, reset and wrap.
`timescale 1ns/1ps
module tb_nfi_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_cmd_toggle_pause = 1'b0;
  logic       i_cmd_step = 1'b0;
  logic       i_cmd_speed_up = 1'b0;
  logic       i_cmd_speed_down = 1'b0;
  logic       i_NFI_allowed = 1'b1;
  logic       i_done = 1'b0;
  logic       o_go, o_busy, o_paused;
  logic [1:0] o_speed;
  logic [3:0] o_gen_cnt;

  int   errors = 0;
  int   checks = 0;
  bit   eng_en = 1'b0;
  bit   eng_active = 1'b0;
  int   eng_k = 0;
  logic force_done = 1'b0;
  int   n;
  int   gos;

  typedef struct packed {
    logic [4:0] in;   // {toggle, step, up, down, done}
    logic [2:0] ob;   // {go, busy, paused}
    logic [1:0] sp;
    logic [3:0] g;
  } vec_t;
  vec_t tbl[$];

  nfi_scheduler #(
    .BASE_PERIOD(4), .N_SPEEDS(4), .RESET_SPEED(3), .START_PAUSED(0), .GEN_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_cmd_toggle_pause(i_cmd_toggle_pause), .i_cmd_step(i_cmd_step),
    .i_cmd_speed_up(i_cmd_speed_up), .i_cmd_speed_down(i_cmd_speed_down),
    .i_NFI_allowed(i_NFI_allowed), .i_done(i_done),
    .o_go(o_go), .o_busy(o_busy), .o_paused(o_paused),
    .o_speed(o_speed), .o_gen_cnt(o_gen_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: engine model returns i_done in the 4th cycle after o_go.
  task automatic cyc();
    logic d;
    d = 1'b0;
    if (eng_en && eng_active) begin
      if (eng_k == 4) begin
        d = 1'b1;
        eng_active = 1'b0;
      end
      eng_k++;
    end
    i_done = d | force_done;
    @(posedge clk);
    #1;
    if (o_go && eng_en) begin
      eng_active = 1'b1;
      eng_k = 0;
    end
  endtask

  task automatic wait_go(input int limit, output int cnt);
    cnt = 0;
    do begin
      cyc();
      cnt++;
    end while (!o_go && cnt < limit);
    if (!o_go) cnt = -1;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k;
    k = 0;
    do begin
      cyc();
      k++;
    end while ((o_busy || o_go) && k < limit);
    chk(name, int'(o_busy | o_go), 0);
  endtask

  task automatic add(input logic [4:0] in, input logic [2:0] ob,
                     input logic [1:0] sp, input logic [3:0] g);
    tbl.push_back('{in, ob, sp, g});
  endtask

  initial begin
    // Steps while paused (starts PAUSED, speed 3, gen 4)
    add(5'b01000, 3'b101, 2'd3, 4'd4);  // step edge -> go next cycle
    add(5'b01000, 3'b011, 2'd3, 4'd4);  // held step: no new event
    add(5'b00000, 3'b011, 2'd3, 4'd4);
    add(5'b01000, 3'b011, 2'd3, 4'd4);  // step while BUSY dropped
    add(5'b00001, 3'b001, 2'd3, 4'd5);  // done
    add(5'b00001, 3'b001, 2'd3, 4'd5);  // spurious done while paused
    add(5'b01000, 3'b101, 2'd3, 4'd5);
    add(5'b00001, 3'b011, 2'd3, 4'd5);  // done in ISSUE ignored
    add(5'b00001, 3'b001, 2'd3, 4'd6);
    add(5'b00000, 3'b001, 2'd3, 4'd6);
    add(5'b01000, 3'b101, 2'd3, 4'd6);
    add(5'b00000, 3'b011, 2'd3, 4'd6);
    add(5'b00001, 3'b001, 2'd3, 4'd7);
    add(5'b00000, 3'b001, 2'd3, 4'd7);
    // Speed down x5 from 3, then simultaneous up/down
    add(5'b00010, 3'b001, 2'd2, 4'd7);  add(5'b00000, 3'b001, 2'd2, 4'd7);
    add(5'b00010, 3'b001, 2'd1, 4'd7);  add(5'b00000, 3'b001, 2'd1, 4'd7);
    add(5'b00010, 3'b001, 2'd0, 4'd7);  add(5'b00000, 3'b001, 2'd0, 4'd7);
    add(5'b00010, 3'b001, 2'd0, 4'd7);  add(5'b00000, 3'b001, 2'd0, 4'd7);
    add(5'b00010, 3'b001, 2'd0, 4'd7);  add(5'b00000, 3'b001, 2'd0, 4'd7);
    add(5'b00110, 3'b001, 2'd0, 4'd7);  add(5'b00000, 3'b001, 2'd0, 4'd7);
    // Speed up x4 with saturation at 3, then simultaneous at the top
    add(5'b00100, 3'b001, 2'd1, 4'd7);  add(5'b00000, 3'b001, 2'd1, 4'd7);
    add(5'b00100, 3'b001, 2'd2, 4'd7);  add(5'b00000, 3'b001, 2'd2, 4'd7);
    add(5'b00100, 3'b001, 2'd3, 4'd7);  add(5'b00000, 3'b001, 2'd3, 4'd7);
    add(5'b00100, 3'b001, 2'd3, 4'd7);  add(5'b00000, 3'b001, 2'd3, 4'd7);
    add(5'b00110, 3'b001, 2'd3, 4'd7);  add(5'b00000, 3'b001, 2'd3, 4'd7);
    // Back down to the slowest level (period 32)
    add(5'b00010, 3'b001, 2'd2, 4'd7);  add(5'b00000, 3'b001, 2'd2, 4'd7);
    add(5'b00010, 3'b001, 2'd1, 4'd7);  add(5'b00000, 3'b001, 2'd1, 4'd7);
    add(5'b00010, 3'b001, 2'd0, 4'd7);  add(5'b00000, 3'b001, 2'd0, 4'd7);

    // Reset state
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    chk("rst_go", int'(o_go), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_paused", int'(o_paused), 0);
    chk("rst_speed", int'(o_speed), 3);
    chk("rst_gen", int'(o_gen_cnt), 0);

    // Free run at speed 3: period 4, pulses 9 apart
    eng_en = 1'b1;
    wait_go(100, n);  chk("run_first_go", n, 4);
    wait_go(100, n);  chk("run_spacing1", n, 9);
    chk("run_gen1", int'(o_gen_cnt), 1);
    wait_go(100, n);  chk("run_spacing2", n, 9);
    chk("run_gen2", int'(o_gen_cnt), 2);
    wait_idle("run_idle", 20);
    chk("run_gen3", int'(o_gen_cnt), 3);

    // Toggle held 20 cycles from the ISSUE cycle: one toggle, gen completes
    wait_go(100, n);  chk("tog_go", n, 4);
    gos = 0;
    i_cmd_toggle_pause = 1'b1;
    repeat (20) begin cyc(); if (o_go) gos++; end
    i_cmd_toggle_pause = 1'b0;
    repeat (20) begin cyc(); if (o_go) gos++; end
    chk("tog_no_go", gos, 0);
    chk("tog_paused", int'(o_paused), 1);
    chk("tog_busy", int'(o_busy), 0);
    chk("tog_gen", int'(o_gen_cnt), 4);

    // Vector table: steps and speed changes while paused
    eng_en = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      {i_cmd_toggle_pause, i_cmd_step, i_cmd_speed_up, i_cmd_speed_down, force_done} = tbl[i].in;
      cyc();
      chk($sformatf("v%0d_go", i), int'(o_go), int'(tbl[i].ob[2]));
      chk($sformatf("v%0d_busy", i), int'(o_busy), int'(tbl[i].ob[1]));
      chk($sformatf("v%0d_paused", i), int'(o_paused), int'(tbl[i].ob[0]));
      chk($sformatf("v%0d_speed", i), int'(o_speed), int'(tbl[i].sp));
      chk($sformatf("v%0d_gen", i), int'(o_gen_cnt), int'(tbl[i].g));
    end
    {i_cmd_toggle_pause, i_cmd_step, i_cmd_speed_up, i_cmd_speed_down, force_done} = 5'b00000;

    // Resume at speed 0: period 32
    eng_en = 1'b1;
    i_cmd_toggle_pause = 1'b1;
    cyc();
    i_cmd_toggle_pause = 1'b0;
    chk("resume_paused", int'(o_paused), 0);
    wait_go(200, n);  chk("slow_first_go", n, 32);

    // Stall 10 cycles mid-count with a spurious done: go delayed by 10
    repeat (15) cyc();
    i_NFI_allowed = 1'b0;
    for (int i = 0; i < 10; i++) begin
      force_done = (i == 4);
      cyc();
    end
    force_done = 1'b0;
    i_NFI_allowed = 1'b1;
    wait_go(200, n);  chk("stall_go", n, 22);
    chk("stall_gen", int'(o_gen_cnt), 8);

    // Reset while BUSY, then a late done
    eng_en = 1'b0;
    eng_active = 1'b0;
    cyc();
    chk("pre_rst_busy", int'(o_busy), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_go", int'(o_go), 0);
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_paused", int'(o_paused), 0);
    chk("mid_rst_speed", int'(o_speed), 3);
    chk("mid_rst_gen", int'(o_gen_cnt), 0);
    force_done = 1'b1;
    cyc();
    force_done = 1'b0;
    chk("late_done_gen", int'(o_gen_cnt), 0);
    chk("late_done_busy", int'(o_busy), 0);

    // 4-bit generation counter wraps after 16 generations
    eng_en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      wait_go(50, n);
      chk($sformatf("wrap_go%0d", i), int'(n > 0), 1);
    end
    wait_idle("wrap_idle15", 20);
    chk("wrap_gen15", int'(o_gen_cnt), 15);
    wait_go(50, n);
    chk("wrap_go15", int'(n > 0), 1);
    wait_idle("wrap_idle16", 20);
    chk("wrap_gen16", int'(o_gen_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nfi_scheduler.md
Name: nfi_scheduler

Overview:
Generation-step scheduler for the Game of Life core. It decides when the field engine computes the next generation, replacing the fixed-interval pulse with:
- selectable speed levels
- pause/resume and single-step commands
- a go/done handshake with the field engine
- a generation counter
It sits between the command decoder (buttons/UART) and the next-field-iteration engine.

Parameters:
BASE_PERIOD, 4, clk cycles between generations at the fastest speed; must be >= 1.
N_SPEEDS, 4, number of speed levels; level s gives period BASE_PERIOD << (N_SPEEDS-1-s).
RESET_SPEED, 0, speed level loaded at reset; must be < N_SPEEDS.
START_PAUSED, 0, 1 = come out of reset paused.
GEN_W, 16, generation counter width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_cmd_toggle_pause  in  1  level; rising edge toggles pause
i_cmd_step  in  1  level; rising edge requests one generation while paused
i_cmd_speed_up  in  1  level; rising edge increments speed level
i_cmd_speed_down  in  1  level; rising edge decrements speed level
i_NFI_allowed  in  1  engine/field free; period counter advances only when high
i_done  in  1  one-cycle pulse from engine: generation complete
o_go  out  1  one-cycle pulse: start next generation
o_busy  out  1  high from o_go until i_done accepted
o_paused  out  1  current pause state
o_speed  out  $clog2(N_SPEEDS) (min 1)  current speed level
o_gen_cnt  out  GEN_W  completed generations

Behaviour:
- Clocking and reset:
  - Single clock, rising edge.
  - rst synchronous, active-high.
  - Reset values: o_go=0, o_busy=0, o_gen_cnt=0, o_speed=RESET_SPEED, o_paused=START_PAUSED, period cnt=0, all edge-detect registers=0, state=PAUSED if START_PAUSED else RUN.
  - rst asserted mid-handshake abandons the generation; a late i_done after reset is ignored (state not BUSY).
- Edge detection: each cmd input is registered once; an event is in=1 and prev=0. A held level produces exactly one event.
- State machine:
  - RUN:
    - cnt increments each cycle i_NFI_allowed=1, holds otherwise.
    - When cnt >= period-1 and i_NFI_allowed=1: next state ISSUE, cnt<=0.
  - PAUSED:
    - cnt held at 0.
    - Step event -> ISSUE.
    - Toggle event -> RUN, o_paused<=0.
  - ISSUE: o_go=1 for exactly this one cycle; next state BUSY.
  - BUSY:
    - o_busy=1; waits for i_done.
    - On i_done: o_gen_cnt <= o_gen_cnt+1 (wraps mod 2^GEN_W).
    - Then next state is PAUSED if o_paused else RUN, with cnt=0.
- Toggle in RUN/ISSUE/BUSY flips o_paused on the next cycle. The pending generation in ISSUE/BUSY still completes; the flag decides the state after BUSY.
- Step events outside PAUSED are dropped (no queueing).
- i_done outside BUSY, including in the ISSUE cycle, is ignored.
- Latency: step event at edge-detect output -> o_go 1 cycle later. In RUN at speed s with i_NFI_allowed tied high, o_go pulses are spaced period + 2 + engine latency cycles apart.
- Speed:
  - Up/down saturate at N_SPEEDS-1 and 0.
  - Simultaneous up and down events -> no change.
  - The change takes effect immediately. Because the compare is >=, a shorter new period with cnt already past it fires on the next allowed cycle.
- Width rule: cnt width = $clog2(BASE_PERIOD << (N_SPEEDS-1)) (min 1). Period arithmetic is done at that width, so no overflow.

Test Plan:
- Reset, BASE_PERIOD=4, N_SPEEDS=4, RESET_SPEED=3, i_NFI_allowed=1, i_done returned 3 cycles after o_go -> o_go pulses every 4+2+3=9 cycles; o_gen_cnt counts 1,2,3.
- Toggle held high 20 cycles while in RUN -> o_paused=1 after exactly one toggle. The in-flight generation completes; no further o_go.
- While paused, 3 separated step pulses -> exactly 3 o_go pulses, each 1 cycle after the step edge; o_gen_cnt +3. A step while BUSY produces no extra o_go.
- Speed down ×5 from level 3 -> o_speed 2,1,0,0,0 (saturates); period becomes 32. Speed up and down in the same cycle -> o_speed unchanged.
- i_NFI_allowed low for 10 cycles mid-count -> cnt frozen, o_go delayed by exactly 10 cycles. A spurious i_done in RUN leaves o_gen_cnt unchanged.
- rst asserted while BUSY, then i_done pulses -> all outputs return to reset values; o_gen_cnt stays 0. GEN_W=4 after 16 generations -> o_gen_cnt wraps to 0.
